simulation_pwm: RTL and testbench

- Free-running, self-timed waveform generator with one clock input and one output `r`.
- After reset it waits a fixed start-up delay, then drives `r` as a periodic PWM waveform. Period and duty are set by parameters.
- Used as a heartbeat / activity indicator and as a clock-divided stimulus source in simulation and FPGA top levels. It has no data inputs.

---
 rtl/simulation_pkg.sv | 26 ++
 rtl/simulation_pwm_core.sv | 65 ++++++
 rtl/simulation_pwm.sv | 69 ++++++
 tb/tb_simulation_pwm.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/simulation_pkg.sv
// -----------------------------------------------------------------------------
// simulation_pkg
// Shared types, default parameter values and a width helper for the
// simulation_pwm heartbeat / PWM generator.
//   state_e      : top-level sequencing states (start-up wait, free run)
//   DEF_*        : default PERIOD / HIGH_CYCLES / START_DELAY
//   clog2_min1() : counter width for values 0..value-1, never below 1 bit
// -----------------------------------------------------------------------------
package simulation_pkg;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_PERIOD      = 10;
  localparam int DEF_HIGH_CYCLES = 5;
  localparam int DEF_START_DELAY = 4;

  // Width needed to hold 0..value-1; a 1-bit minimum keeps degenerate
  // parameterisations (value of 0, 1 or 2) from producing zero-width vectors.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/simulation_pwm_core.sv
// -----------------------------------------------------------------------------
// simulation_pwm_core
// Phase counter and registered compare that shape the PWM waveform.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset (phase=0, r_o=0)
//   start_i : load phase 0 and drive the first cycle of the waveform
//   en_i    : advance the phase by one cycle (free-running mode)
//   r_o     : registered PWM output
// With neither start_i nor en_i the core simply holds its state.
// -----------------------------------------------------------------------------
module simulation_pwm_core
  import simulation_pkg::*;
#(
  parameter int PERIOD      = DEF_PERIOD,
  parameter int HIGH_CYCLES = DEF_HIGH_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic en_i,
  output logic r_o
);

  localparam int            PW         = clog2_min1(PERIOD);
  localparam logic [PW-1:0] PHASE_LAST = PW'(PERIOD - 1);
  localparam logic [31:0]   HIGH_U     = 32'(HIGH_CYCLES);

  // NOTE: declaration initialisers equal the reset values so the output is
  // never X on an FPGA or in simulation when rst is tied low.
  logic [PW-1:0] phase_q = '0;
  logic          r_q     = 1'b0;
  logic [PW-1:0] phase_d;
  logic          r_d;

  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    phase_d = phase_q;
    r_d     = r_q;
    if (start_i) begin
      phase_d = '0;
      r_d     = (HIGH_CYCLES > 0);
    end else if (en_i) begin
      // Wrap straight from PERIOD-1 to 0 so the waveform has no gap cycle.
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
      // 32-bit unsigned compare: HIGH_CYCLES may exceed the phase range.
      r_d     = (32'(phase_d) < HIGH_U);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      r_q     <= 1'b0;
    end else begin
      phase_q <= phase_d;
      r_q     <= r_d;
    end
  end

  assign r_o = r_q;

endmodule

// File: rtl/simulation_pwm.sv
// -----------------------------------------------------------------------------
// simulation_pwm
// Self-timed heartbeat: after reset release it waits START_DELAY cycles, then
// emits a PWM waveform of PERIOD cycles with HIGH_CYCLES cycles high.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset; may be tied 0
//   r   : registered PWM output
// The top holds the start-up delay counter and the WAIT/RUN sequencer; the
// waveform itself comes from simulation_pwm_core.
// -----------------------------------------------------------------------------
module simulation_pwm
  import simulation_pkg::*;
#(
  parameter int PERIOD      = DEF_PERIOD,
  parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int START_DELAY = DEF_START_DELAY
) (
  input  logic clk,
  input  logic rst,
  output logic r
);

  if (PERIOD < 1) begin : g_bad_period
    $error("simulation_pwm: PERIOD must be >= 1");
  end

  localparam int            DW         = clog2_min1(START_DELAY + 1);
  localparam logic [DW-1:0] DELAY_LAST = (START_DELAY == 0) ? '0 : DW'(START_DELAY - 1);

  state_e        state_q     = ST_WAIT;
  logic [DW-1:0] delay_cnt_q = '0;
  logic          wait_done;
  logic          core_start;
  logic          core_en;

  // With no start-up delay the very first edge after release enters RUN.
  assign wait_done  = (START_DELAY == 0) || (delay_cnt_q == DELAY_LAST);
  assign core_start = (state_q == ST_WAIT) && wait_done;
  assign core_en    = (state_q == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_WAIT;
      delay_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          // The counter stops at its terminal value rather than overshooting.
          if (wait_done) state_q <= ST_RUN;
          else           delay_cnt_q <= delay_cnt_q + 1'b1;
        end
        ST_RUN:  state_q <= ST_RUN;
        default: state_q <= ST_WAIT;
      endcase
    end
  end

  simulation_pwm_core #(
    .PERIOD      (PERIOD),
    .HIGH_CYCLES (HIGH_CYCLES)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .start_i (core_start),
    .en_i    (core_en),
    .r_o     (r)
  );

endmodule

// File: tb/tb_simulation_pwm.sv
// -----------------------------------------------------------------------------
// tb_simulation_pwm
// Six parameterisations of simulation_pwm share one clock. Instance 1 has its
// reset tied low; the others share a reset driven with random pulses. The
// driver pushes the expected r of every instance for each edge (and for each
// reset assertion) into a scoreboard queue; the monitor pops and compares on
// the falling clock edge and 1 ns after reset rises.
// Reference: with n = rising edges since reset release and s = max(D,1),
//   r(n) = (n >= s) && ((n - s) mod P) < H.
// -----------------------------------------------------------------------------
module tb_simulation_pwm;

  localparam int N_DUT = 6;
  localparam int P_T [N_DUT] = '{10, 10, 1, 7, 7, 8};
  localparam int H_T [N_DUT] = '{ 5,  5, 1, 0, 9, 3};
  localparam int D_T [N_DUT] = '{ 4,  4, 0, 4, 4, 2};
  localparam int FREE_ID = 1;

  typedef struct {
    int   id;
    int   edge_n;
    logic exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N_DUT-1:0] r_vec;

  exp_t sb_q[$];
  int   n_cmp     = 0;
  int   n_bad     = 0;
  int   edge_n    = 0;
  int   free_edge = 0;

  simulation_pwm #(.PERIOD(10), .HIGH_CYCLES(5), .START_DELAY(4))
    u_def  (.clk(clk), .rst(rst),  .r(r_vec[0]));
  simulation_pwm #(.PERIOD(10), .HIGH_CYCLES(5), .START_DELAY(4))
    u_free (.clk(clk), .rst(1'b0), .r(r_vec[1]));
  simulation_pwm #(.PERIOD(1),  .HIGH_CYCLES(1), .START_DELAY(0))
    u_p1   (.clk(clk), .rst(rst),  .r(r_vec[2]));
  simulation_pwm #(.PERIOD(7),  .HIGH_CYCLES(0), .START_DELAY(4))
    u_h0   (.clk(clk), .rst(rst),  .r(r_vec[3]));
  simulation_pwm #(.PERIOD(7),  .HIGH_CYCLES(9), .START_DELAY(4))
    u_h9   (.clk(clk), .rst(rst),  .r(r_vec[4]));
  simulation_pwm #(.PERIOD(8),  .HIGH_CYCLES(3), .START_DELAY(2))
    u_p8   (.clk(clk), .rst(rst),  .r(r_vec[5]));

  // Clock starts at 100 ns; first rising edge at 110 ns.
  initial begin
    #100;
    forever #10 clk = ~clk;
  end

  function automatic logic model_r(input int n, input int p, input int h, input int d);
    int s;
    s = (d == 0) ? 1 : d;
    if (n < s) return 1'b0;
    return (((n - s) % p) < h);
  endfunction

  task automatic push_exp(input int id, input int n);
    exp_t e;
    e.id     = id;
    e.edge_n = n;
    e.exp    = model_r(n, P_T[id], H_T[id], D_T[id]);
    sb_q.push_back(e);
  endtask

  // One rising edge: count it, queue expectations, return 13 ns later.
  task automatic tick();
    @(posedge clk);
    if (!rst) edge_n++;
    free_edge++;
    for (int i = 0; i < N_DUT; i++) push_exp(i, (i == FREE_ID) ? free_edge : edge_n);
    #13;
  endtask

  // Called 13 ns after an edge: 3 ns pulse, optionally held over extra edges.
  task automatic reset_pulse(input int hold);
    for (int i = 0; i < N_DUT; i++) if (i != FREE_ID) push_exp(i, 0);
    edge_n = 0;
    rst    = 1'b1;
    #3;
    for (int k = 0; k < hold; k++) begin
      tick();
      #3;
    end
    rst = 1'b0;
  endtask

  // Monitor: drains the scoreboard at each sampling point.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (r_vec[e.id] !== e.exp) begin
          n_bad++;
          $display("FAIL dut%0d_r edge=%0d t=%0t got=%b want=%b",
                   e.id, e.edge_n, $time, r_vec[e.id], e.exp);
        end
      end
    end
  end

  // Driver.
  initial begin
    int guard;
    #1;
    // Before any clock edge every output must be 0, including the
    // never-reset instance.
    for (int i = 0; i < N_DUT; i++) push_exp(i, 0);
    rst = 1'b1;
    #99;
    rst = 1'b0;

    repeat (40) tick();

    // Reset while the default instance is in its high phase.
    guard = 0;
    while (!model_r(edge_n, P_T[0], H_T[0], D_T[0]) && guard < 20) begin
      tick();
      guard++;
    end
    reset_pulse(0);
    repeat (45) tick();

    // Randomised run lengths and reset hold times.
    repeat (12) begin
      repeat ($urandom_range(3, 60)) tick();
      reset_pulse(int'($urandom_range(0, 3)));
    end
    repeat (110) tick();

    @(negedge clk);
    #2;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
